rob_completion_arbiter: RTL and testbench

ROB_COMPLETION_ARBITER -- requirements
Module: rob_completion_arbiter

---
 rtl/rob_completion_arbiter_if.sv | 46 ++++
 rtl/rob_completion_arbiter.sv | 102 ++++++++++
 tb/tb_rob_completion_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/rob_completion_arbiter_if.sv
// Completion request/response bundle between the functional units and the ROB
// completion arbiter; field names match the original flat port list.
interface rob_completion_arbiter_if #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned addrSize = 4
);
    logic [NUM_REQ-1:0]              req_valid_i;
    logic [NUM_REQ-1:0]              req_ready_o;
    logic [NUM_REQ*(addrSize+1)-1:0] req_tag_i;
    logic [NUM_REQ*70-1:0]           req_data_i;
    logic [NUM_REQ*64-1:0]           req_extra_i;

    logic                            completionWriteEn_o;
    logic [addrSize:0]               completionWriteAddr_o;
    logic [69:0]                     completionWriteData_o;
    logic [63:0]                     completionWriteDataExtra_o;
    logic                            tag_err_o;

    // Functional-unit / ROB side
    modport master (
        output req_valid_i,
        output req_tag_i,
        output req_data_i,
        output req_extra_i,
        input  req_ready_o,
        input  completionWriteEn_o,
        input  completionWriteAddr_o,
        input  completionWriteData_o,
        input  completionWriteDataExtra_o,
        input  tag_err_o
    );

    // Arbiter side
    modport slave (
        input  req_valid_i,
        input  req_tag_i,
        input  req_data_i,
        input  req_extra_i,
        output req_ready_o,
        output completionWriteEn_o,
        output completionWriteAddr_o,
        output completionWriteData_o,
        output completionWriteDataExtra_o,
        output tag_err_o
    );
endinterface

// File: rtl/rob_completion_arbiter.sv
// Round-robin arbiter selecting one functional-unit completion per cycle and
// registering it onto the ROB completion write port.
module rob_completion_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ROBsize  = 16,
    parameter int unsigned addrSize = $clog2(ROBsize)
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic flush_i,
    rob_completion_arbiter_if.slave bus
);
    localparam int unsigned TW    = addrSize + 1;
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               xfer;
    logic               tag_zero;
    logic [TW-1:0]      sel_tag;
    logic [69:0]        sel_data;
    logic [63:0]        sel_extra;

    logic               wr_en_q;
    logic [TW-1:0]      wr_addr_q;
    logic [69:0]        wr_data_q;
    logic [63:0]        wr_extra_q;
    logic               tag_err_q;

    // Rotating priority search starting at ptr; the winner's payload is muxed
    // in the same pass so no second index decode is needed.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx       = 0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        sel_tag   = '0;
        sel_data  = '0;
        sel_extra = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && bus.req_valid_i[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
                sel_tag    = bus.req_tag_i[idx*TW +: TW];
                sel_data   = bus.req_data_i[idx*70 +: 70];
                sel_extra  = bus.req_extra_i[idx*64 +: 64];
            end
        end
        if (flush_i || !reset_n_i) begin
            grant = '0;
        end
    end

    assign xfer     = |grant;
    assign tag_zero = (sel_tag == '0);

    always_comb begin
        ptr_nxt = ptr;
        if (xfer) begin
            ptr_nxt = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr        <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_extra_q <= '0;
            tag_err_q  <= 1'b0;
        end else begin
            ptr     <= ptr_nxt;
            wr_en_q <= xfer && !tag_zero;
            // A tag-0 transfer is consumed but leaves the write port untouched.
            if (xfer && !tag_zero) begin
                wr_addr_q  <= sel_tag;
                wr_data_q  <= sel_data;
                wr_extra_q <= sel_extra;
            end
            if (xfer && tag_zero) begin
                tag_err_q <= 1'b1;
            end
        end
    end

    assign bus.req_ready_o                = grant;
    assign bus.completionWriteEn_o        = wr_en_q;
    assign bus.completionWriteAddr_o      = wr_addr_q;
    assign bus.completionWriteData_o      = wr_data_q;
    assign bus.completionWriteDataExtra_o = wr_extra_q;
    assign bus.tag_err_o                  = tag_err_q;
endmodule

// File: tb/tb_rob_completion_arbiter.sv
// Directed bench for rob_completion_arbiter: expected grants are given per
// step, expected write-port contents are queued and compared one cycle later.
module tb_rob_completion_arbiter;
    localparam int unsigned NR = 4;
    localparam int unsigned AW = 4;
    localparam int unsigned TW = AW + 1;
    localparam logic [NR-1:0] ALL = 4'b1111;

    typedef struct {
        logic          en;
        logic [TW-1:0] addr;
        logic [69:0]   data;
        logic [63:0]   extra;
        logic          err;
    } exp_t;

    logic clk_i = 1'b0;
    logic reset_n_i = 1'b1;
    logic flush_i = 1'b0;

    always #5 clk_i = ~clk_i;

    rob_completion_arbiter_if #(.NUM_REQ(NR), .addrSize(AW)) bus ();

    rob_completion_arbiter #(.NUM_REQ(NR), .ROBsize(16), .addrSize(AW)) dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .flush_i  (flush_i),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [TW-1:0] tags   [NR];
    logic [69:0]   datas  [NR];
    logic [63:0]   extras [NR];

    logic [TW-1:0] m_addr;
    logic [69:0]   m_data;
    logic [63:0]   m_extra;
    logic          m_err;
    exp_t          q[$];

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [NR-1:0] valid, input logic fl);
        bus.req_valid_i = valid;
        flush_i = fl;
        for (int k = 0; k < NR; k++) begin
            bus.req_tag_i[k*TW +: TW]  = tags[k];
            bus.req_data_i[k*70 +: 70] = datas[k];
            bus.req_extra_i[k*64 +: 64] = extras[k];
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = q.pop_front();
            chk("wr_en",   bus.completionWriteEn_o,        e.en);
            chk("wr_addr", bus.completionWriteAddr_o,      e.addr);
            chk("wr_data", bus.completionWriteData_o,      e.data);
            chk("wr_extra", bus.completionWriteDataExtra_o, e.extra);
            chk("tag_err", bus.tag_err_o,                  e.err);
        end
    endtask

    // One clock: drive, check grant combinationally, queue expected output,
    // then compare the registered output after the edge. g < 0 means no grant.
    task automatic cycle(input logic [NR-1:0] valid, input logic fl, input int g);
        exp_t          e;
        logic [NR-1:0] er;
        drive(valid, fl);
        #1;
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("ready", bus.req_ready_o, er);
        e.en = 1'b0;
        if (g >= 0) begin
            if (tags[g] != '0) begin
                m_addr  = tags[g];
                m_data  = datas[g];
                m_extra = extras[g];
                e.en    = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
        e.addr  = m_addr;
        e.data  = m_data;
        e.extra = m_extra;
        e.err   = m_err;
        q.push_back(e);
        @(posedge clk_i);
        #1;
        check_out();
    endtask

    task automatic check_reset_state(input string name);
        chk({name, "_ready"}, bus.req_ready_o,                '0);
        chk({name, "_en"},    bus.completionWriteEn_o,        '0);
        chk({name, "_addr"},  bus.completionWriteAddr_o,      '0);
        chk({name, "_data"},  bus.completionWriteData_o,      '0);
        chk({name, "_extra"}, bus.completionWriteDataExtra_o, '0);
        chk({name, "_err"},   bus.tag_err_o,                  '0);
    endtask

    task automatic model_reset();
        q.delete();
        m_addr  = '0;
        m_data  = '0;
        m_extra = '0;
        m_err   = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NR; k++) begin
            tags[k]   = TW'(k + 1);
            datas[k]  = 70'h3_0000_0000_0000_0100 + 70'(k);
            extras[k] = 64'hA5A5_0000_0000_0000 + 64'(k);
        end
        model_reset();

        // Reset with every unit requesting: nothing granted, requests lost
        drive(ALL, 1'b0);
        #2 reset_n_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_reset_state("reset");
        drive('0, 1'b0);
        #3 reset_n_i = 1'b1;

        // Single request from unit 2
        tags[2]   = 5'd5;
        datas[2]  = 70'h2A;
        extras[2] = 64'h7;
        cycle(4'b0100, 1'b0, 2);
        cycle(4'b0000, 1'b0, -1);
        tags[2]   = 5'd3;
        datas[2]  = 70'h3_0000_0000_0000_0102;
        extras[2] = 64'hA5A5_0000_0000_0002;

        // Move pointer to 0, then sustained all-valid rotation 0,1,2,3,0
        cycle(4'b1000, 1'b0, 3);
        cycle(ALL, 1'b0, 0);
        cycle(ALL, 1'b0, 1);
        cycle(ALL, 1'b0, 2);
        cycle(ALL, 1'b0, 3);
        cycle(ALL, 1'b0, 0);

        // Units 1 and 3 with ptr at 2, then confirm ptr back at 2
        cycle(4'b0010, 1'b0, 1);
        cycle(4'b1010, 1'b0, 3);
        cycle(4'b1010, 1'b0, 1);
        cycle(ALL, 1'b0, 2);

        // Tag-0 request: accepted, no write, sticky error
        tags[0] = '0;
        cycle(4'b0001, 1'b0, 0);
        repeat (10) cycle(4'b0000, 1'b0, -1);
        tags[0] = 5'd1;

        // Flush blocks grant and keeps ptr; in-flight write still completes
        cycle(4'b0010, 1'b1, -1);
        cycle(4'b0010, 1'b0, 1);
        cycle(4'b0100, 1'b0, 2);
        cycle(4'b0100, 1'b1, -1);
        cycle(4'b0000, 1'b0, -1);

        // Reset asserted between edges during a burst
        cycle(ALL, 1'b0, 3);
        cycle(ALL, 1'b0, 0);
        #3 reset_n_i = 1'b0;
        #1;
        check_reset_state("midreset");
        model_reset();
        #3 reset_n_i = 1'b1;
        cycle(ALL, 1'b0, 0);
        cycle(ALL, 1'b0, 1);
        cycle(4'b0000, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
